// File: rtl/multi_cycle_control.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with sticky fault flags.
// Define MEM_WAIT_EN to honour i_MemReady with a WAIT_MAX-bounded wait counter.
module multi_cycle_control #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic       i_CLK,
   input  logic       i_RST,
   input  logic [6:0] i_OPCode,
   input  logic       i_MemReady,
   output logic       o_PCWrite,
   output logic       o_IRWrite,
   output logic       o_IorD,
   output logic       o_Branch,
   output logic       o_MemRead,
   output logic       o_MemWrite,
   output logic       o_MemToReg,
   output logic       o_ALUSrc,
   output logic       o_RegWrite,
   output logic [1:0] o_ALUOp,
   output logic       o_Illegal,
   output logic       o_MemErr,
   output logic [2:0] o_State
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      ClsR, ClsI, ClsLoad, ClsStore, ClsBranch
   } class_e;

   state_e state_q, state_d;
   class_e class_q, class_d;
   logic   illegal_q, illegal_d;
   logic   mem_done, wait_expired;
   logic   memerr_q, memerr_d;

`ifdef MEM_WAIT_EN
   logic [7:0] wait_q, wait_d;

   assign mem_done     = i_MemReady;
   // The cycle that would make the not-ready count reach WAIT_MAX is the fault cycle.
   assign wait_expired = !i_MemReady && (wait_q == 8'(WAIT_MAX - 1));
`else
   logic unused_mem_ready;

   assign unused_mem_ready = i_MemReady;
   assign mem_done         = 1'b1;
   assign wait_expired     = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      class_d    = class_q;
      illegal_d  = illegal_q;
      memerr_d   = memerr_q;
`ifdef MEM_WAIT_EN
      wait_d     = '0;
`endif
      o_PCWrite  = 1'b0;
      o_IRWrite  = 1'b0;
      o_IorD     = 1'b0;
      o_Branch   = 1'b0;
      o_MemRead  = 1'b0;
      o_MemWrite = 1'b0;
      o_MemToReg = 1'b0;
      o_ALUSrc   = 1'b0;
      o_RegWrite = 1'b0;
      o_ALUOp    = 2'b00;

      case (state_q)
         StFetch: begin
            o_MemRead = 1'b1;
            if (mem_done) begin
               o_IRWrite = 1'b1;
               o_PCWrite = 1'b1;
               state_d   = StDecode;
            end else if (wait_expired) begin
               state_d  = StHalt;
               memerr_d = 1'b1;
            end else begin
`ifdef MEM_WAIT_EN
               wait_d = wait_q + 8'd1;
`endif
            end
         end
         StDecode: begin
            state_d = StExec;
            case (i_OPCode)
               7'b0110011: class_d = ClsR;
               7'b0010011: class_d = ClsI;
               7'b0000011: class_d = ClsLoad;
               7'b0100011: class_d = ClsStore;
               7'b1100011: class_d = ClsBranch;
               default: begin
                  state_d   = StHalt;
                  illegal_d = 1'b1;
               end
            endcase
         end
         StExec: begin
            case (class_q)
               ClsR: begin
                  o_ALUOp = 2'b10;
                  state_d = StWb;
               end
               ClsI: begin
                  o_ALUOp  = 2'b11;
                  o_ALUSrc = 1'b1;
                  state_d  = StWb;
               end
               ClsLoad, ClsStore: begin
                  o_ALUSrc = 1'b1;
                  state_d  = StMem;
               end
               default: begin
                  o_ALUOp  = 2'b01;
                  o_Branch = 1'b1;
                  state_d  = StFetch;
               end
            endcase
         end
         StMem: begin
            o_IorD     = 1'b1;
            o_MemRead  = (class_q == ClsLoad);
            o_MemWrite = (class_q == ClsStore);
            if (mem_done) begin
               state_d = (class_q == ClsLoad) ? StWb : StFetch;
            end else if (wait_expired) begin
               state_d  = StHalt;
               memerr_d = 1'b1;
            end else begin
`ifdef MEM_WAIT_EN
               wait_d = wait_q + 8'd1;
`endif
            end
         end
         StWb: begin
            o_RegWrite = 1'b1;
            o_MemToReg = (class_q == ClsLoad);
            state_d    = StFetch;
         end
         StHalt:  state_d = StHalt;
         default: state_d = StHalt;
      endcase

      // Reset masks every command output in the cycle it is applied.
      if (i_RST) begin
         o_PCWrite  = 1'b0;
         o_IRWrite  = 1'b0;
         o_IorD     = 1'b0;
         o_Branch   = 1'b0;
         o_MemRead  = 1'b0;
         o_MemWrite = 1'b0;
         o_MemToReg = 1'b0;
         o_ALUSrc   = 1'b0;
         o_RegWrite = 1'b0;
         o_ALUOp    = 2'b00;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q   <= StFetch;
         class_q   <= ClsR;
         illegal_q <= 1'b0;
         memerr_q  <= 1'b0;
`ifdef MEM_WAIT_EN
         wait_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         illegal_q <= illegal_d;
         memerr_q  <= memerr_d;
`ifdef MEM_WAIT_EN
         wait_q    <= wait_d;
`endif
      end
   end

   assign o_Illegal = illegal_q;
   assign o_MemErr  = memerr_q;
   assign o_State   = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: stimulus pushes expected per-cycle snapshots,
// a negedge monitor pops and compares state plus the packed command/flag vector.
module tb_multi_cycle_control;

   localparam logic [6:0] OpR   = 7'b0110011;
   localparam logic [6:0] OpI   = 7'b0010011;
   localparam logic [6:0] OpLd  = 7'b0000011;
   localparam logic [6:0] OpSt  = 7'b0100011;
   localparam logic [6:0] OpBr  = 7'b1100011;
   localparam logic [6:0] OpBad = 7'b1101111;

   // {PCWrite,IRWrite,IorD,Branch,MemRead,MemWrite,MemToReg,ALUSrc,RegWrite,ALUOp,Illegal,MemErr}
   localparam logic [12:0] PCW  = 13'h1000;
   localparam logic [12:0] IRW  = 13'h0800;
   localparam logic [12:0] IORD = 13'h0400;
   localparam logic [12:0] BR   = 13'h0200;
   localparam logic [12:0] MR   = 13'h0100;
   localparam logic [12:0] MW   = 13'h0080;
   localparam logic [12:0] M2R  = 13'h0040;
   localparam logic [12:0] ASRC = 13'h0020;
   localparam logic [12:0] RW   = 13'h0010;
   localparam logic [12:0] OP01 = 13'h0004;
   localparam logic [12:0] OP10 = 13'h0008;
   localparam logic [12:0] OP11 = 13'h000C;
   localparam logic [12:0] ILL  = 13'h0002;
   localparam logic [12:0] MERR = 13'h0001;
   localparam logic [12:0] FET  = PCW | IRW | MR;

   typedef struct {
      string       name;
      logic [2:0]  st;
      logic [12:0] cmd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  op  = 7'd0;
   logic        rdy = 1'b1;
   logic        pcw, irw, iord, br, mr, mw, m2r, asrc, rw, ill, merr;
   logic [1:0]  aluop;
   logic [2:0]  st;
   logic [12:0] act_cmd;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   multi_cycle_control #(.WAIT_MAX(4)) dut (
      .i_CLK(clk), .i_RST(rst), .i_OPCode(op), .i_MemReady(rdy),
      .o_PCWrite(pcw), .o_IRWrite(irw), .o_IorD(iord), .o_Branch(br),
      .o_MemRead(mr), .o_MemWrite(mw), .o_MemToReg(m2r), .o_ALUSrc(asrc),
      .o_RegWrite(rw), .o_ALUOp(aluop), .o_Illegal(ill), .o_MemErr(merr),
      .o_State(st)
   );

   assign act_cmd = {pcw, irw, iord, br, mr, mw, m2r, asrc, rw, aluop, ill, merr};

   // Monitor: one expected snapshot per cycle in which stimulus pushed one.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (st !== e.st || act_cmd !== e.cmd) begin
               errors++;
               $display("FAIL %s: got state=%0d cmd=%h, expected state=%0d cmd=%h",
                        e.name, st, act_cmd, e.st, e.cmd);
            end
         end
      end
   end

   task automatic cyc(input string nm, input logic r, input logic [6:0] o, input logic rd,
                      input logic [2:0] exp_st, input logic [12:0] exp_cmd);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      op  = o;
      rdy = rd;
      e.name = nm;
      e.st   = exp_st;
      e.cmd  = exp_cmd;
      sb_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      cyc("rst_hold", 1, OpR, 1, 3'd0, 13'h0);

      // R-type; junk opcode outside DECODE must not matter
      cyc("r_fetch", 0, OpR,   1, 3'd0, FET);
      cyc("r_dec",   0, OpR,   1, 3'd1, 13'h0);
      cyc("r_exec",  0, OpBad, 1, 3'd2, OP10);
      cyc("r_wb",    0, OpBad, 1, 3'd4, RW);

      cyc("i_fetch", 0, OpI, 1, 3'd0, FET);
      cyc("i_dec",   0, OpI, 1, 3'd1, 13'h0);
      cyc("i_exec",  0, OpR, 1, 3'd2, OP11 | ASRC);
      cyc("i_wb",    0, OpR, 1, 3'd4, RW);

      cyc("ld_fetch", 0, OpLd, 1, 3'd0, FET);
      cyc("ld_dec",   0, OpLd, 1, 3'd1, 13'h0);
      cyc("ld_exec",  0, OpSt, 1, 3'd2, ASRC);
      cyc("ld_mem",   0, OpSt, 1, 3'd3, IORD | MR);
      cyc("ld_wb",    0, OpSt, 1, 3'd4, M2R | RW);

      cyc("st_fetch", 0, OpSt, 1, 3'd0, FET);
      cyc("st_dec",   0, OpSt, 1, 3'd1, 13'h0);
      cyc("st_exec",  0, OpLd, 1, 3'd2, ASRC);
      cyc("st_mem",   0, OpLd, 1, 3'd3, IORD | MW);

      cyc("br_fetch", 0, OpBr, 1, 3'd0, FET);
      cyc("br_dec",   0, OpBr, 1, 3'd1, 13'h0);
      cyc("br_exec",  0, OpR,  1, 3'd2, BR | OP01);

`ifdef MEM_WAIT_EN
      // STORE with three wait cycles in MEM, then a FETCH that times out
      cyc("w_fetch", 0, OpSt, 1, 3'd0, FET);
      cyc("w_dec",   0, OpSt, 1, 3'd1, 13'h0);
      cyc("w_exec",  0, OpSt, 1, 3'd2, ASRC);
      for (int i = 0; i < 3; i++) cyc("w_mem_wait", 0, OpSt, 0, 3'd3, IORD | MW);
      cyc("w_mem_done", 0, OpSt, 1, 3'd3, IORD | MW);
      for (int i = 0; i < 4; i++) cyc("w_fetch_wait", 0, OpR, 0, 3'd0, MR);
      cyc("w_halt",    0, OpR, 0, 3'd5, MERR);
      cyc("w_halt_rst", 1, OpR, 1, 3'd5, MERR);
      cyc("w_rst2",    1, OpR, 1, 3'd0, 13'h0);
`else
      // i_MemReady is ignored: LOAD still takes five cycles with ready low
      cyc("nr_fetch", 0, OpLd, 0, 3'd0, FET);
      cyc("nr_dec",   0, OpLd, 0, 3'd1, 13'h0);
      cyc("nr_exec",  0, OpLd, 0, 3'd2, ASRC);
      cyc("nr_mem",   0, OpLd, 0, 3'd3, IORD | MR);
      cyc("nr_wb",    0, OpLd, 0, 3'd4, M2R | RW);
`endif

      // Reset during MEM of a STORE with ready low aborts the write
      cyc("ab_fetch", 0, OpSt, 1, 3'd0, FET);
      cyc("ab_dec",   0, OpSt, 1, 3'd1, 13'h0);
      cyc("ab_exec",  0, OpSt, 1, 3'd2, ASRC);
      cyc("ab_mem_rst", 1, OpSt, 0, 3'd3, 13'h0);
      cyc("ab_after",   0, OpBad, 1, 3'd0, FET);

      // Illegal opcode decoded, sticky flag through HALT, cleared by reset
      cyc("ill_dec", 0, OpBad, 1, 3'd1, 13'h0);
      for (int i = 0; i < 10; i++) cyc("ill_halt", 0, OpR, 1, 3'd5, ILL);
      cyc("ill_rst",  1, OpR, 1, 3'd5, ILL);
      cyc("ill_post", 0, OpR, 1, 3'd0, FET);

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: MULTI_CYCLE_CONTROL

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: max consecutive not-ready memory cycles before fault (range 1..255).
REQ-002 SHALL have port i_CLK  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port i_RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_OPCode  input  7  instruction opcode field from instruction register.
REQ-005 SHALL have port i_MemReady  input  1  memory completes current read/write this cycle.
REQ-006 SHALL have ports o_PCWrite, o_IRWrite, o_IorD  output  1 each: PC update, IR load, memory address select (0=PC, 1=ALU result).
REQ-007 SHALL have ports o_Branch, o_MemRead, o_MemWrite, o_MemToReg, o_ALUSrc, o_RegWrite  output  1 each: same meaning as the single-cycle main control.
REQ-008 SHALL have port o_ALUOp  output  2  ALU control class (00 add, 01 branch compare, 10 R-type funct, 11 I-type funct).
REQ-009 SHALL have ports o_Illegal, o_MemErr  output  1 each: sticky fault flags; o_State  output  3  current state code.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6,7 SHALL transition to HALT.
REQ-011 SHALL drive all command outputs as Moore functions of state and latched opcode class; unlisted outputs 0 in every state.
REQ-012 FETCH: o_MemRead=1, o_IorD=0; on memory completion o_IRWrite=1, o_PCWrite=1 that cycle, next DECODE; else stay.
REQ-013 DECODE: latch i_OPCode into internal class register; 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH -> EXEC; any other -> HALT with o_Illegal set.
REQ-014 EXEC: R: o_ALUOp=10, o_ALUSrc=0 -> WB; I: 11, o_ALUSrc=1 -> WB; LOAD/STORE: 00, o_ALUSrc=1 -> MEM; BRANCH: 01, o_ALUSrc=0, o_Branch=1 -> FETCH.
REQ-015 MEM: o_IorD=1; LOAD o_MemRead=1, STORE o_MemWrite=1; on completion LOAD -> WB, STORE -> FETCH; else stay.
REQ-016 WB: o_RegWrite=1, o_MemToReg=1 for LOAD else 0 -> FETCH.
REQ-017 HALT: all command outputs 0; stay until reset; o_Illegal/o_MemErr hold.
REQ-018 Instruction latency SHALL be: BRANCH 3 cycles, R/I 4, STORE 4, LOAD 5, each FETCH/MEM with zero wait cycles.
REQ-019 o_PCWrite and o_IRWrite SHALL each pulse exactly one cycle per instruction.
REQ-020 o_MemRead and o_MemWrite SHALL never be 1 in the same cycle.
REQ-021 i_OPCode changes outside DECODE SHALL not affect EXEC/MEM/WB behaviour.

Reset
REQ-022 i_RST high at an edge SHALL set state FETCH, opcode class R, wait counter 0, o_Illegal=0, o_MemErr=0.
REQ-023 While i_RST is high all command outputs SHALL be forced 0 and o_State SHALL read 0 after the first reset edge.
REQ-024 Reset asserted mid-instruction (any state incl. HALT) SHALL abort it; no o_RegWrite/o_MemWrite/o_PCWrite pulse after the reset edge.

Configuration
REQ-025 Macro MEM_WAIT_EN SHALL select the memory handshake.
REQ-026 With MEM_WAIT_EN defined: completion = i_MemReady high; an 8-bit wait counter counts consecutive not-ready cycles in FETCH/MEM, clears on completion or state change; reaching WAIT_MAX -> HALT with o_MemErr=1.
REQ-027 Without MEM_WAIT_EN: i_MemReady ignored, every FETCH/MEM completes in one cycle, no counter, o_MemErr tied 0.

Verification
REQ-028 Reset, then i_OPCode=0110011, ready always 1 -> states 0,1,2,4,0; o_RegWrite=1 only in state 4; o_ALUOp=10 in state 2.
REQ-029 i_OPCode=0000011, ready 1 -> states 0,1,2,3,4; o_MemRead=1,o_IorD=1 in 3; o_MemToReg=1,o_RegWrite=1 in 4; 5 cycles.
REQ-030 i_OPCode=1100011 -> states 0,1,2,0; o_Branch=1,o_ALUOp=01 in 2; no o_RegWrite/o_MemWrite.
REQ-031 i_OPCode=1101111 at DECODE -> HALT, o_Illegal=1 held 10 cycles; i_RST pulse -> state 0, o_Illegal=0.
REQ-032 MEM_WAIT_EN, WAIT_MAX=4, STORE, ready low 3 cycles in MEM then high -> o_MemWrite high 4 cycles, then FETCH, o_MemErr=0; ready low 4 cycles in FETCH -> HALT, o_MemErr=1.
REQ-033 Reset asserted in MEM of STORE with ready low -> next cycle state 0, o_MemWrite=0, no write completion.
